int_entry_unit: RTL and testbench
=================================

INT_ENTRY_UNIT -- requirements
Module: int_entry_unit

Interface
REQ-001 SHALL have parameter RESET_IE, default 1'b0, reset value of the global interrupt-enable bit.
REQ-002 SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_int, input, 1, level interrupt request from the interrupt handler.
REQ-005 SHALL have port i_vec_addr, input, 32, vector address of the pending interrupt from the handler.
REQ-006 SHALL have port o_ack, output, 1, one-cycle acknowledge pulse to the handler.
REQ-007 SHALL have port i_retire, input, 1, instruction-boundary pulse from the core.
REQ-008 SHALL have port i_pc_next, input, 32, PC of the next instruction, valid with i_retire.
REQ-009 SHALL have port i_reti, input, 1, return-from-interrupt instruction retiring (qualified by i_retire).
REQ-010 SHALL have ports i_csr_wr_en (1), i_csr_addr (3), i_csr_wdata (32), inputs, core CSR write bus.
REQ-011 SHALL have ports o_hdl_wr_en (1), o_hdl_addr (3), o_hdl_wr_port (32), outputs, vector-table write bus to the handler.
REQ-012 SHALL have ports o_redirect (1), o_redirect_pc (32), outputs, one-cycle PC redirect to fetch.
REQ-013 SHALL have ports o_ie (1), o_epc (32), o_in_isr (1), outputs, status.

Function
REQ-014 SHALL implement FSM states IDLE, PENDING, IN_ISR.
REQ-015 IDLE -> PENDING SHALL occur when i_int=1 and ie=1.
REQ-016 PENDING -> IDLE SHALL occur, with no ack, if i_int=0 or ie=0 (spurious/cancelled request).
REQ-017 PENDING with i_int=1, ie=1, i_retire=1 SHALL enter IN_ISR: epc<=i_pc_next, pie<=ie, ie<=0, and next cycle o_ack=1, o_redirect=1, o_redirect_pc=i_vec_addr as sampled at that edge.
REQ-018 o_ack and o_redirect SHALL be registered single-cycle pulses; latency from the sampled i_retire to the pulse is exactly 1 cycle.
REQ-019 IN_ISR with i_retire=1 and i_reti=1 SHALL return to IDLE: ie<=pie, and next cycle o_redirect=1, o_redirect_pc=epc.
REQ-020 i_reti without i_retire, or i_reti in IDLE/PENDING, SHALL be ignored.
REQ-021 Nesting SHALL NOT occur: i_int is ignored in IN_ISR; after return, at least one IDLE cycle precedes the next PENDING.
REQ-022 CSR addr 0-3 writes SHALL be forwarded to the handler bus (o_hdl_wr_en/addr/wr_port) registered, 1-cycle latency, same addr/data.
REQ-023 CSR addr 4 write SHALL set ie<=wdata[0]; addr 5 write SHALL set epc<=wdata; addr 6-7 writes SHALL be ignored.
REQ-024 Entry (REQ-017) and a same-cycle CSR addr 4 or 5 write SHALL resolve with entry winning; the CSR write is dropped.
REQ-025 Return (REQ-019) and a same-cycle CSR addr 4 write SHALL resolve with return winning (ie<=pie).
REQ-026 o_in_isr SHALL be 1 exactly while in IN_ISR; o_ie and o_epc SHALL reflect current registers.
REQ-027 o_redirect and o_ack SHALL never assert in the same cycle unless both result from an entry.

Reset
REQ-028 While i_rst_n=0, state SHALL be IDLE, ie=RESET_IE, pie=0, epc=0, and o_ack, o_redirect, o_hdl_wr_en, o_in_isr=0, o_redirect_pc=0, o_hdl_addr=0, o_hdl_wr_port=0.
REQ-029 Reset asserted mid-ISR or mid-pending SHALL abandon the interrupt with no ack or redirect pulse.

Verification
REQ-030 Write addr 4 data 1; i_int=1, i_vec_addr=0x0000_0100; i_retire with i_pc_next=0x0000_2004 -> next cycle o_ack=1, o_redirect=1, o_redirect_pc=0x100; o_epc=0x2004, o_ie=0, o_in_isr=1.
REQ-031 From REQ-030, i_retire+i_reti -> next cycle o_redirect=1, o_redirect_pc=0x2004, o_ie=1, o_in_isr=0.
REQ-032 ie=1, i_int pulses 1 cycle then 0 before any i_retire -> no o_ack, no o_redirect, FSM back to IDLE.
REQ-033 CSR write addr 2 data 0xDEAD_BEEF -> next cycle o_hdl_wr_en=1, o_hdl_addr=2, o_hdl_wr_port=0xDEAD_BEEF; write addr 6 -> no output change.
REQ-034 In IN_ISR, i_int held 1 with i_retire each cycle -> no second o_ack; i_retire+i_reti simultaneous with CSR addr 4 data 0 -> o_ie=1 after return.
REQ-035 Reset asserted during IN_ISR -> o_in_isr=0, o_epc=0, o_ie=RESET_IE, no pulses after release.

Source files
------------

// File: rtl/int_entry_unit.sv
// rtl/int_entry_unit.sv - interrupt entry/return sequencer with IE/EPC CSRs and vector-table write forwarding
module int_entry_unit #(
    parameter logic RESET_IE = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_int,
    input  logic [31:0] i_vec_addr,
    output logic        o_ack,
    input  logic        i_retire,
    input  logic [31:0] i_pc_next,
    input  logic        i_reti,
    input  logic        i_csr_wr_en,
    input  logic [2:0]  i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    output logic        o_hdl_wr_en,
    output logic [2:0]  o_hdl_addr,
    output logic [31:0] o_hdl_wr_port,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_ie,
    output logic [31:0] o_epc,
    output logic        o_in_isr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_IN_ISR  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        ie_q;
    logic        pie_q;
    logic [31:0] epc_q;
    logic        entry;
    logic        ret;
    logic        csr_ie_wr;
    logic        csr_epc_wr;
    logic        csr_fwd_wr;

    // Next-state logic; entry and return are only taken on an instruction boundary.
    always_comb begin
        state_d    = state_q;
        entry      = 1'b0;
        ret        = 1'b0;
        csr_ie_wr  = i_csr_wr_en && (i_csr_addr == 3'd4);
        csr_epc_wr = i_csr_wr_en && (i_csr_addr == 3'd5);
        csr_fwd_wr = i_csr_wr_en && !i_csr_addr[2];
        case (state_q)
            S_IDLE: begin
                if (i_int && ie_q) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (!(i_int && ie_q)) begin
                    state_d = S_IDLE;
                end else if (i_retire) begin
                    entry   = 1'b1;
                    state_d = S_IN_ISR;
                end
            end
            S_IN_ISR: begin
                // i_int is deliberately ignored here so handlers never nest.
                if (i_retire && i_reti) begin
                    ret     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IE/PIE/EPC: entry beats any CSR write, return beats an IE write but not an EPC write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ie_q  <= RESET_IE;
            pie_q <= 1'b0;
            epc_q <= 32'd0;
        end else if (entry) begin
            epc_q <= i_pc_next;
            pie_q <= ie_q;
            ie_q  <= 1'b0;
        end else begin
            if (ret) begin
                ie_q <= pie_q;
            end else if (csr_ie_wr) begin
                ie_q <= i_csr_wdata[0];
            end
            if (csr_epc_wr) begin
                epc_q <= i_csr_wdata;
            end
        end
    end

    // Registered ack/redirect pulses; redirect target holds between pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack         <= 1'b0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= 32'd0;
        end else begin
            o_ack      <= entry;
            o_redirect <= entry || ret;
            if (entry) begin
                o_redirect_pc <= i_vec_addr;
            end else if (ret) begin
                o_redirect_pc <= epc_q;
            end
        end
    end

    // Forward vector-table CSR writes (addr 0-3) to the handler one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hdl_wr_en   <= 1'b0;
            o_hdl_addr    <= 3'd0;
            o_hdl_wr_port <= 32'd0;
        end else begin
            o_hdl_wr_en <= csr_fwd_wr;
            if (csr_fwd_wr) begin
                o_hdl_addr    <= i_csr_addr;
                o_hdl_wr_port <= i_csr_wdata;
            end
        end
    end

    assign o_ie     = ie_q;
    assign o_epc    = epc_q;
    assign o_in_isr = (state_q == S_IN_ISR);

endmodule

// File: tb/tb_int_entry_unit.sv
// tb/tb_int_entry_unit.sv - randomized and directed checks of int_entry_unit against a reference model
module tb_int_entry_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_int;
    logic [31:0] i_vec_addr;
    logic        o_ack;
    logic        i_retire;
    logic [31:0] i_pc_next;
    logic        i_reti;
    logic        i_csr_wr_en;
    logic [2:0]  i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic        o_hdl_wr_en;
    logic [2:0]  o_hdl_addr;
    logic [31:0] o_hdl_wr_port;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_ie;
    logic [31:0] o_epc;
    logic        o_in_isr;

    int total = 0;
    int bad   = 0;

    // reference model: interrupt lifecycle as two flags plus architectural registers
    bit          m_waiting;
    bit          m_handling;
    bit          m_ie;
    bit          m_pie;
    logic [31:0] m_epc;
    bit          m_ack;
    bit          m_redir;
    logic [31:0] m_rpc;
    bit          m_wen;
    logic [2:0]  m_waddr;
    logic [31:0] m_wdata;

    always #5 i_clk = ~i_clk;

    int_entry_unit dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_int         (i_int),
        .i_vec_addr    (i_vec_addr),
        .o_ack         (o_ack),
        .i_retire      (i_retire),
        .i_pc_next     (i_pc_next),
        .i_reti        (i_reti),
        .i_csr_wr_en   (i_csr_wr_en),
        .i_csr_addr    (i_csr_addr),
        .i_csr_wdata   (i_csr_wdata),
        .o_hdl_wr_en   (o_hdl_wr_en),
        .o_hdl_addr    (o_hdl_addr),
        .o_hdl_wr_port (o_hdl_wr_port),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc),
        .o_ie          (o_ie),
        .o_epc         (o_epc),
        .o_in_isr      (o_in_isr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting  = 0;
        m_handling = 0;
        m_ie       = 0;
        m_pie      = 0;
        m_epc      = 32'd0;
        m_ack      = 0;
        m_redir    = 0;
        m_rpc      = 32'd0;
        m_wen      = 0;
        m_waddr    = 3'd0;
        m_wdata    = 32'd0;
    endtask

    // one clock of architectural behaviour, computed from pre-edge values
    task automatic model_step();
        bit          take;
        bit          leave;
        bit          req;
        bit          n_ie;
        logic [31:0] n_epc;
        req   = i_int && m_ie;
        take  = m_waiting && req && i_retire;
        leave = m_handling && i_retire && i_reti;
        n_ie  = m_ie;
        n_epc = m_epc;
        m_ack   = take;
        m_redir = take || leave;
        m_wen   = i_csr_wr_en && (i_csr_addr < 3'd4);
        if (m_wen) begin
            m_waddr = i_csr_addr;
            m_wdata = i_csr_wdata;
        end
        if (take) begin
            m_rpc      = i_vec_addr;
            n_epc      = i_pc_next;
            m_pie      = m_ie;
            n_ie       = 0;
            m_waiting  = 0;
            m_handling = 1;
        end else begin
            if (leave) begin
                m_rpc      = m_epc;
                n_ie       = m_pie;
                m_handling = 0;
            end else if (i_csr_wr_en && i_csr_addr == 3'd4) begin
                n_ie = i_csr_wdata[0];
            end
            if (i_csr_wr_en && i_csr_addr == 3'd5) n_epc = i_csr_wdata;
            if (m_waiting) m_waiting = req;
            else if (!m_handling && !leave) m_waiting = req;
        end
        m_ie  = n_ie;
        m_epc = n_epc;
    endtask

    task automatic check_all(input string where);
        chk({where, ":ack"},    {31'd0, o_ack},       {31'd0, m_ack});
        chk({where, ":redir"},  {31'd0, o_redirect},  {31'd0, m_redir});
        chk({where, ":rpc"},    o_redirect_pc,        m_rpc);
        chk({where, ":ie"},     {31'd0, o_ie},        {31'd0, m_ie});
        chk({where, ":epc"},    o_epc,                m_epc);
        chk({where, ":in_isr"}, {31'd0, o_in_isr},    {31'd0, m_handling});
        chk({where, ":wen"},    {31'd0, o_hdl_wr_en}, {31'd0, m_wen});
        chk({where, ":waddr"},  {29'd0, o_hdl_addr},  {29'd0, m_waddr});
        chk({where, ":wdata"},  o_hdl_wr_port,        m_wdata);
    endtask

    task automatic set_in(input bit intr, input logic [31:0] vec, input bit ret, input logic [31:0] pc,
                          input bit reti, input bit wr, input logic [2:0] addr, input logic [31:0] wd);
        i_int       = intr;
        i_vec_addr  = vec;
        i_retire    = ret;
        i_pc_next   = pc;
        i_reti      = reti;
        i_csr_wr_en = wr;
        i_csr_addr  = addr;
        i_csr_wdata = wd;
    endtask

    task automatic idle_in();
        set_in(0, 32'd0, 0, 32'd0, 0, 0, 3'd0, 32'd0);
    endtask

    // called at a negedge with inputs set; returns at the next negedge
    task automatic cycle(input string where);
        @(posedge i_clk);
        if (i_rst_n) model_step();
        #1;
        check_all(where);
        @(negedge i_clk);
    endtask

    task automatic async_reset(input string where);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all(where);
        idle_in();
        @(negedge i_clk);
        cycle(where);
        i_rst_n = 1'b1;
    endtask

    initial begin
        idle_in();
        i_rst_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // basic entry then return
        set_in(0, 0, 0, 0, 0, 1, 3'd4, 32'd1);              cycle("ie_set");
        set_in(1, 32'h100, 0, 0, 0, 0, 3'd0, 0);            cycle("pend");
        set_in(1, 32'h100, 1, 32'h2004, 0, 0, 3'd0, 0);     cycle("entry");
        chk("entry_ack", {31'd0, o_ack}, 32'd1);
        chk("entry_rpc", o_redirect_pc, 32'h100);
        chk("entry_epc", o_epc, 32'h2004);
        chk("entry_isr", {31'd0, o_in_isr}, 32'd1);
        idle_in();                                           cycle("isr_idle");
        set_in(0, 0, 1, 32'h3000, 1, 0, 3'd0, 0);           cycle("return");
        chk("ret_rpc", o_redirect_pc, 32'h2004);
        chk("ret_ie", {31'd0, o_ie}, 32'd1);
        chk("ret_isr", {31'd0, o_in_isr}, 32'd0);

        // cancelled request
        set_in(1, 32'h200, 0, 0, 0, 0, 3'd0, 0);            cycle("spur_pend");
        idle_in();                                           cycle("spur_drop");
        set_in(0, 0, 1, 32'h40, 0, 0, 3'd0, 0);             cycle("spur_retire");
        chk("spur_ack", {31'd0, o_ack}, 32'd0);

        // forwarding and ignored address
        set_in(0, 0, 0, 0, 0, 1, 3'd2, 32'hDEAD_BEEF);      cycle("fwd2");
        chk("fwd_data", o_hdl_wr_port, 32'hDEAD_BEEF);
        set_in(0, 0, 0, 0, 0, 1, 3'd6, 32'h1234_5678);      cycle("fwd6");
        chk("fwd6_data", o_hdl_wr_port, 32'hDEAD_BEEF);

        // no nesting; return wins against ie write
        set_in(1, 32'h500, 0, 0, 0, 0, 3'd0, 0);            cycle("n_pend");
        set_in(1, 32'h500, 1, 32'h600, 0, 1, 3'd5, 32'h77); cycle("n_entry");
        chk("n_epc_win", o_epc, 32'h600);
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h900, 1, 32'h700 + k, 0, 0, 3'd0, 0); cycle("n_hold");
            chk("n_noack", {31'd0, o_ack}, 32'd0);
        end
        set_in(1, 32'h900, 1, 32'h800, 1, 1, 3'd4, 32'd0);  cycle("n_ret");
        chk("n_ret_ie", {31'd0, o_ie}, 32'd1);
        set_in(1, 32'h900, 0, 0, 0, 0, 3'd0, 0);            cycle("n_gap");
        chk("n_gap_ack", {31'd0, o_ack}, 32'd0);

        // reset during handler
        set_in(1, 32'h900, 1, 32'hA00, 0, 0, 3'd0, 0);      cycle("r_entry");
        chk("r_isr", {31'd0, o_in_isr}, 32'd1);
        async_reset("r_mid");
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 1, 32'hB00, 1, 0, 3'd0, 0);        cycle("r_after");
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
            end else begin
                set_in($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                       3'($urandom_range(0, 7)), $urandom);
                cycle("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
